// File: rtl/mnist_frame_loader_pkg.sv
// mnist_frame_loader_pkg: shared widths, frame size defaults and FSM state encoding.
package mnist_frame_loader_pkg;
  localparam int DEF_NUM_PIXELS = 784;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int PIX_W = 8;
  localparam int PRED_W = 16;
  localparam int RES_W = 4;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;
endpackage

// File: rtl/mnist_frame_loader.sv
// mnist_frame_loader: streams one frame of pixels into image memory, starts the network,
// and holds its prediction until the consumer accepts it.
module mnist_frame_loader
  import mnist_frame_loader_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PIX_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  s_pixel,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              net_start,
  input  logic              net_done,
  input  logic [PRED_W-1:0] net_prediction,
  output logic [RES_W-1:0]  m_result,
  output logic              m_error,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_count
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [RES_W-1:0] res_q, res_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last;
  assign last = pix_q == ADDR_W'(NUM_PIXELS - 1);
  assign s_ready = state_q == ST_LOAD;
  assign mem_we = s_valid && s_ready;
  assign mem_addr = pix_q;
  assign mem_wdata = DATA_W'(s_pixel) << PIX_SHIFT;
  assign net_start = state_q == ST_START;
  assign m_valid = state_q == ST_RESULT;
  assign busy = state_q != ST_LOAD;
  assign m_result = res_q;
  assign m_error = err_q;
  assign frame_count = cnt_q;
  always_comb begin
    state_d = state_q;
    pix_d = pix_q;
    res_d = res_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_LOAD: if (mem_we) begin
        pix_d = last ? '0 : pix_q + 1'b1;
        state_d = last ? ST_START : ST_LOAD;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: if (net_done) begin
        res_d = net_prediction[RES_W-1:0];
        err_d = net_prediction > PRED_W'(9);
        state_d = ST_RESULT;
      end
      ST_RESULT: if (m_ready) begin
        cnt_d = cnt_q + 1'b1;
        state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      pix_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pix_q <= pix_d;
      res_q <= res_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: doc/mnist_frame_loader.md
MNIST_FRAME_LOADER -- requirements
Module: mnist_frame_loader

Interface
REQ-001 Parameter NUM_PIXELS, default 784, pixels per frame.
REQ-002 Parameter ADDR_W, default 10, image memory address width.
REQ-003 Parameter DATA_W, default 16, image memory word width.
REQ-004 Parameter PIX_SHIFT, default 0, left shift applied to each pixel before write.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 s_pixel  input  8  unsigned incoming pixel.
REQ-008 s_valid  input  1  s_pixel valid.
REQ-009 s_ready  output  1  loader accepts pixel this cycle.
REQ-010 mem_we  output  1  image memory write enable.
REQ-011 mem_addr  output  ADDR_W  image memory write address.
REQ-012 mem_wdata  output  DATA_W  image memory write data.
REQ-013 net_start  output  1  one-cycle network start pulse.
REQ-014 net_done  input  1  network finished pulse.
REQ-015 net_prediction  input  16  network argmax digit.
REQ-016 m_result  output  4  captured digit.
REQ-017 m_error  output  1  captured prediction exceeded 9.
REQ-018 m_valid  output  1  result available.
REQ-019 m_ready  input  1  result consumer accepts.
REQ-020 busy  output  1  high in any state except LOAD.
REQ-021 frame_count  output  16  completed (consumed) frames, wraps at 65535->0.

Function
REQ-022 FSM states LOAD, START, WAIT, RESULT; LOAD after reset.
REQ-023 LOAD: s_ready=1; beat accepted when s_valid&&s_ready.
REQ-024 Accepted beat drives, same cycle (combinational), mem_we=1, mem_addr=pixel counter, mem_wdata=zero-extended s_pixel << PIX_SHIFT, truncated to DATA_W.
REQ-025 Pixel counter increments per accepted beat; s_valid low holds counter, no write.
REQ-026 Beat accepted at counter NUM_PIXELS-1: counter clears to 0, next state START.
REQ-027 START lasts exactly one cycle with net_start=1, then WAIT; latency last-beat cycle N -> net_start at N+1.
REQ-028 s_ready=0 and mem_we=0 in START, WAIT, RESULT; s_valid ignored there.
REQ-029 WAIT: on net_done=1 capture m_result=net_prediction[3:0], m_error=(net_prediction>9), go RESULT; m_valid=1 from next cycle.
REQ-030 net_done in LOAD or START ignored; no capture, no transition.
REQ-031 RESULT: m_valid=1; m_result, m_error stable until handshake.
REQ-032 m_valid&&m_ready: frame_count+1, next state LOAD, m_valid=0 next cycle.
REQ-033 m_ready while m_valid=0 has no effect.
REQ-034 Pixel counter never exceeds NUM_PIXELS-1; no address wrap inside a frame.

Reset
REQ-035 rst asserted asynchronously forces state LOAD, pixel counter 0, frame_count 0, m_result 0, m_error 0, m_valid 0, net_start 0.
REQ-036 Reset mid-frame or mid-WAIT discards partial frame; no net_start issued; next accepted beat writes address 0.
REQ-037 s_ready=1 in first cycle after rst deasserts.

Structure
REQ-038 Shared package holds NUM_PIXELS, pixel/data widths, and FSM state encoding constants.
REQ-039 Single module; no sub-module needed (counter and FSM inline).

Verification
REQ-040 784 back-to-back beats pixel=k&8'hFF -> writes addr 0..783 with data k&8'hFF, net_start pulse exactly one cycle after beat 783.
REQ-041 s_valid toggling every other cycle -> 784 writes, no gaps in address, no duplicate addresses.
REQ-042 net_done with net_prediction=7 -> m_result=7, m_error=0, m_valid held 5 cycles with m_ready=0, then handshake -> frame_count=1, s_ready=1 next cycle.
REQ-043 net_prediction=12 -> m_error=1, m_result=12; net_done pulsed during LOAD -> no m_valid.
REQ-044 rst asserted at beat 400 -> all outputs to reset values immediately; new full frame starts at address 0 and completes normally.
REQ-045 PIX_SHIFT=8, pixel=0xFF -> mem_wdata=0xFF00.
